// File: rtl/sort_pkg.sv
// Shared constants and state encoding for the four-element sort/unload block.
package sort_pkg;
  localparam int N         = 4;
  localparam int WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SORT = 2'd1,
    EMIT = 2'd2
  } state_t;
endpackage

// File: rtl/sort_cmp_swap.sv
// Unsigned compare-exchange: first/second come out in the requested order; ties keep input order.
module sort_cmp_swap #(
  parameter int WIDTH = 8
)(
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             ascending,
  output logic [WIDTH-1:0] first,
  output logic [WIDTH-1:0] second
);
  logic swap;

  assign swap   = ascending ? (x > y) : (x < y);
  assign first  = swap ? y : x;
  assign second = swap ? x : y;
endmodule

// File: rtl/sort_unload.sv
// Captures four elements, sorts them with four odd-even transposition passes,
// then unloads them serially over a valid/ready handshake.
module sort_unload
  import sort_pkg::*;
#(
  parameter int WIDTH     = WIDTH_DEF,
  parameter bit ASCENDING = 1'b1
)(
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] ra,
  input  logic [WIDTH-1:0] rb,
  input  logic [WIDTH-1:0] rc,
  input  logic [WIDTH-1:0] rd,
  output logic             busy,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             last
);
  state_t state, nxt;
  logic [1:0] pass;
  logic [1:0] idx;
  logic [N-1:0][WIDTH-1:0] slot, sw;
  logic [WIDTH-1:0] a_x, a_y, a_f, a_s, b_f, b_s;
  logic hs;

  assign hs = dout_valid & dout_ready;

  // Even passes use both exchangers on (0,1),(2,3); odd passes reuse the first on (1,2).
  assign a_x = pass[0] ? slot[1] : slot[0];
  assign a_y = pass[0] ? slot[2] : slot[1];

  sort_cmp_swap #(.WIDTH(WIDTH)) u_cmp_a (
    .x(a_x), .y(a_y), .ascending(ASCENDING), .first(a_f), .second(a_s)
  );
  sort_cmp_swap #(.WIDTH(WIDTH)) u_cmp_b (
    .x(slot[2]), .y(slot[3]), .ascending(ASCENDING), .first(b_f), .second(b_s)
  );

  always_comb begin
    sw = slot;
    if (!pass[0]) begin
      sw[0] = a_f;
      sw[1] = a_s;
      sw[2] = b_f;
      sw[3] = b_s;
    end else begin
      sw[1] = a_f;
      sw[2] = a_s;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (load) nxt = SORT;
      SORT:    if (pass == 2'(N-1)) nxt = EMIT;
      EMIT:    if (hs && idx == 2'(N-1)) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
  end

  // The first EMIT cycle primes the output register; valid rises one edge later.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slot       <= '0;
      pass       <= '0;
      idx        <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      last       <= 1'b0;
    end else begin
      case (state)
        IDLE: if (load) begin
          slot[0] <= ra;
          slot[1] <= rb;
          slot[2] <= rc;
          slot[3] <= rd;
          pass    <= '0;
        end
        SORT: begin
          slot <= sw;
          pass <= pass + 2'd1;
        end
        EMIT: begin
          if (!dout_valid) begin
            dout       <= slot[0];
            dout_valid <= 1'b1;
            last       <= 1'b0;
            idx        <= '0;
          end else if (dout_ready) begin
            if (idx == 2'(N-1)) begin
              dout_valid <= 1'b0;
              last       <= 1'b0;
              idx        <= '0;
            end else begin
              idx  <= idx + 2'd1;
              dout <= slot[idx + 2'd1];
              last <= (idx == 2'(N-2));
            end
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_sort_unload.sv
// Scoreboard bench: ascending and descending instances share stimulus; a negedge monitor checks outputs.
module tb_sort_unload;
  typedef struct { int data; bit last; } exp_t;

  logic clk = 0, reset = 1, load = 0, dout_ready = 1;
  logic [7:0] ra = 0, rb = 0, rc = 0, rd = 0;
  logic busy_a, valid_a, last_a, busy_d, valid_d, last_d;
  logic [7:0] dout_a, dout_d;

  int checks = 0, failures = 0;
  int mode = 0, pc = 0;
  exp_t qa[$], qd[$];
  logic pv[2], pl[2], pr;
  logic [7:0] pd[2];

  sort_unload #(.WIDTH(8), .ASCENDING(1)) u_asc (
    .clk(clk), .reset(reset), .load(load), .ra(ra), .rb(rb), .rc(rc), .rd(rd),
    .busy(busy_a), .dout(dout_a), .dout_valid(valid_a), .dout_ready(dout_ready), .last(last_a));
  sort_unload #(.WIDTH(8), .ASCENDING(0)) u_dsc (
    .clk(clk), .reset(reset), .load(load), .ra(ra), .rb(rb), .rc(rc), .rd(rd),
    .busy(busy_d), .dout(dout_d), .dout_valid(valid_d), .dout_ready(dout_ready), .last(last_d));

  always #5 clk = ~clk;

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  // Ready generator: 0 always ready, 1 pattern 1,0,0 repeating, 2 random, 3 manual.
  always @(posedge clk) begin
    #1;
    case (mode)
      0: dout_ready = 1'b1;
      1: begin dout_ready = (pc % 3 == 0); pc++; end
      2: dout_ready = 1'($urandom_range(0, 1));
      default: ;
    endcase
  end

  task automatic mon(input int i, input logic v, input logic [7:0] d, input logic l);
    exp_t e;
    if (pv[i] && !pr) begin
      checks++;
      if (!v || d != pd[i] || l != pl[i]) begin
        failures++;
        $display("FAIL hold[%0d] got=%0d/%0d/%0d want=1/%0d/%0d", i, v, d, l, pd[i], pl[i]);
      end
    end
    if (v && dout_ready) begin
      if ((i == 0 ? qa.size() : qd.size()) == 0) begin
        checks++; failures++;
        $display("FAIL unexpected[%0d] got=%0d want=none", i, d);
      end else begin
        e = (i == 0) ? qa.pop_front() : qd.pop_front();
        chk(i == 0 ? "asc_dout" : "dsc_dout", int'(d), e.data);
        chk(i == 0 ? "asc_last" : "dsc_last", int'(l), int'(e.last));
      end
    end
    pv[i] = v; pd[i] = d; pl[i] = l;
  endtask

  always @(negedge clk) begin
    if (reset) begin
      pv[0] = 0; pv[1] = 0;
    end else begin
      mon(0, valid_a, dout_a, last_a);
      mon(1, valid_d, dout_d, last_d);
    end
    pr = dout_ready;
  end

  task automatic push_exp(input int a, input int b, input int c, input int d);
    int q[$];
    q = {a, b, c, d};
    q.sort();
    for (int i = 0; i < 4; i++) qa.push_back('{q[i], i == 3});
    q.reverse();
    for (int i = 0; i < 4; i++) qd.push_back('{q[i], i == 3});
  endtask

  // Leaves the bench at load-edge + 1ns.
  task automatic do_load(input int a, input int b, input int c, input int d, input bit nowait);
    if (!nowait) begin @(posedge clk); #1; end
    ra = 8'(a); rb = 8'(b); rc = 8'(c); rd = 8'(d); load = 1;
    push_exp(a, b, c, d);
    @(posedge clk); #1;
    load = 0;
  endtask

  task automatic pulse_ignored();
    @(posedge clk); #1;
    ra = 1; rb = 2; rc = 3; rd = 4; load = 1;
    @(posedge clk); #1;
    load = 0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((qa.size() != 0 || qd.size() != 0) && n < 300) begin
      @(posedge clk); n++;
    end
    chk("drain_timeout", int'(n >= 300), 0);
  endtask

  task automatic check_latency();
    int n = 0;
    chk("busy_after_load", int'(busy_a), 1);
    while (!valid_a && n < 20) begin @(posedge clk); #1; n++; end
    chk("first_valid_latency", n, 5);
  endtask

  initial begin
    int k, a, b, c, d;
    #3;
    chk("rst_dout", int'(dout_a), 0);
    chk("rst_valid", int'(valid_a | valid_d), 0);
    chk("rst_last", int'(last_a | last_d), 0);
    chk("rst_busy", int'(busy_a | busy_d), 0);
    @(posedge clk); #1;
    reset = 0;
    // First load accepted at the first edge after release.
    do_load(40, 10, 30, 20, 1);
    check_latency();
    wait_drain();
    #1;
    chk("idle_busy", int'(busy_a), 0);
    chk("idle_dout_kept", int'(dout_a), 40);

    // Ties and extremes under the 1,0,0 ready pattern.
    mode = 1; pc = 0;
    do_load(7, 7, 0, 255, 0);
    wait_drain();

    // Loads during SORT and during EMIT must be ignored.
    do_load(40, 10, 30, 20, 0);
    pulse_ignored();
    repeat (5) @(posedge clk);
    pulse_ignored();
    wait_drain();
    repeat (10) @(posedge clk);

    // Load coinciding with the final handshake is ignored.
    mode = 0;
    repeat (2) @(posedge clk);
    do_load(9, 3, 200, 3, 0);
    repeat (8) @(posedge clk);
    #1; load = 1;
    @(posedge clk); #1;
    load = 0;
    chk("load_on_final_hs_busy", int'(busy_a), 0);
    repeat (10) @(posedge clk);

    // Reset while 20 is presented by the ascending instance.
    mode = 3; dout_ready = 0;
    do_load(40, 10, 30, 20, 0);
    k = 0;
    while (!valid_a && k < 20) begin @(posedge clk); #1; k++; end
    dout_ready = 1;
    @(posedge clk); #1;
    dout_ready = 0;
    @(posedge clk); #1;
    chk("pre_reset_dout", int'(dout_a), 20);
    #1; reset = 1; #1;
    chk("async_rst_dout", int'(dout_a) + int'(dout_d), 0);
    chk("async_rst_valid", int'(valid_a | valid_d | last_a | last_d), 0);
    chk("async_rst_busy", int'(busy_a | busy_d), 0);
    qa.delete(); qd.delete();
    @(posedge clk); #1;
    mode = 0; dout_ready = 1;
    reset = 0;
    do_load(5, 6, 7, 8, 1);
    check_latency();
    wait_drain();

    // Randomized groups with random backpressure.
    mode = 2;
    for (int i = 0; i < 50; i++) begin
      if ($urandom_range(0, 1) == 0) begin
        a = $urandom_range(0, 3); b = $urandom_range(0, 3);
        c = $urandom_range(0, 3); d = $urandom_range(0, 3);
      end else begin
        a = $urandom_range(0, 255); b = $urandom_range(0, 255);
        c = $urandom_range(0, 255); d = $urandom_range(0, 255);
      end
      do_load(a, b, c, d, 0);
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(0, 6)) @(posedge clk);
        pulse_ignored();
      end
      wait_drain();
    end
    repeat (10) @(posedge clk);
    chk("final_queue_empty", qa.size() + qd.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
